// File: rtl/pc_gen_pkg.sv
// Shared encodings for the fetch-stage PC generator: D-stage next-PC ops,
// branch condition codes and the pending-redirect state.
package pc_gen_pkg;

  // Next-PC operation presented by the D-stage instruction.
  typedef enum logic [3:0] {
    NPC_ADD4 = 4'd0,
    NPC_BRCH = 4'd1,
    NPC_JAL  = 4'd2,
    NPC_JR   = 4'd3
  } npc_op_e;

  // Branch conditions. EQ/NE compare rs with rt; the rest compare signed rs with zero.
  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LEZ = 3'd2,
    BR_GTZ = 3'd3,
    BR_LTZ = 3'd4,
    BR_GEZ = 3'd5
  } br_cond_e;

  // Whether a resolved redirect target is waiting for fetch to accept the delay slot.
  typedef enum logic {
    PS_IDLE = 1'b0,
    PS_PEND = 1'b1
  } pend_state_e;

  // Ops that change control flow regardless of any condition.
  function automatic logic is_jump(input npc_op_e op);
    return (op == NPC_JAL) || (op == NPC_JR);
  endfunction

endpackage

// File: rtl/pc_gen_br_cmp.sv
// Branch condition evaluator: signed compare of rs against rt or against zero.
module br_cmp
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic [2:0]       i_br_cond,
  output logic             o_cond_true
);

  logic w_eq;
  logic w_neg;
  logic w_zero;

  assign w_eq   = (i_rs_val == i_rt_val);
  assign w_neg  = i_rs_val[WIDTH-1];
  assign w_zero = (i_rs_val == '0);

  // Select the condition; unused encodings never branch.
  always_comb begin
    o_cond_true = 1'b0;
    case (br_cond_e'(i_br_cond))
      BR_EQ:   o_cond_true = w_eq;
      BR_NE:   o_cond_true = ~w_eq;
      BR_LEZ:  o_cond_true = w_neg | w_zero;
      BR_GTZ:  o_cond_true = ~w_neg & ~w_zero;
      BR_LTZ:  o_cond_true = w_neg;
      BR_GEZ:  o_cond_true = ~w_neg;
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator. Owns pc_f, resolves D-stage control flow with a
// single delay slot, and parks a redirect that arrives while instruction
// memory is not ready until the delay slot has been fetched.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_imem_ready,
  input  logic [3:0]       i_npc_op,
  input  logic [2:0]       i_br_cond,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic [WIDTH-1:0] i_pc_d,
  input  logic [15:0]      i_imm16,
  input  logic [25:0]      i_imm26,
  input  logic             i_exc_req,
  input  logic             i_eret,
  input  logic [WIDTH-1:0] i_epc,
  output logic [WIDTH-1:0] o_pc_f,
  output logic             o_br_taken,
  output logic             o_adel
);

  localparam logic [WIDTH-1:0] LP_RESET_PC = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] LP_EXC_VEC  = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] LP_LO       = WIDTH'(IMEM_LO);
  localparam logic [WIDTH-1:0] LP_HI       = WIDTH'(IMEM_HI);
  localparam logic [WIDTH-1:0] LP_FOUR     = WIDTH'(4);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_pc;
  pend_state_e      r_state;

  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pend_pc_nxt;
  pend_state_e      w_state_nxt;

  npc_op_e          w_op;
  logic             w_cond_true;
  logic             w_redirect;
  logic             w_advance;
  logic [WIDTH-1:0] w_brch_tgt;
  logic [WIDTH-1:0] w_jal_tgt;
  logic [WIDTH-1:0] w_target;

  assign w_op = npc_op_e'(i_npc_op);

  br_cmp #(.WIDTH(WIDTH)) u_br_cmp (
    .i_rs_val    (i_rs_val),
    .i_rt_val    (i_rt_val),
    .i_br_cond   (i_br_cond),
    .o_cond_true (w_cond_true)
  );

  // Branch target is relative to the delay slot; JAL keeps the current 256MB region.
  assign w_brch_tgt = i_pc_d + LP_FOUR + {{(WIDTH-18){i_imm16[15]}}, i_imm16, 2'b00};
  assign w_jal_tgt  = {i_pc_d[WIDTH-1:28], i_imm26, 2'b00};

  // Pick the redirect target for the D-stage op.
  always_comb begin
    w_target = w_brch_tgt;
    case (w_op)
      NPC_JAL: w_target = w_jal_tgt;
      NPC_JR:  w_target = i_rs_val;
      default: w_target = w_brch_tgt;
    endcase
  end

  // A stalled D instruction re-presents next cycle, so it never redirects while stalled.
  assign w_redirect = ~i_stall & (is_jump(w_op) | ((w_op == NPC_BRCH) & w_cond_true));
  assign w_advance  = i_imem_ready & ~i_stall;

  assign o_br_taken = w_redirect & ~i_reset;
  assign o_pc_f     = r_pc;
  assign o_adel     = (r_pc[1:0] != 2'b00) | (r_pc < LP_LO) | (r_pc > LP_HI);

  // Next-PC priority: exception, eret, redirect, pending target, sequential, hold.
  always_comb begin
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    w_state_nxt   = r_state;
    if (i_exc_req) begin
      w_pc_nxt    = LP_EXC_VEC;
      w_state_nxt = PS_IDLE;
    end else if (i_eret) begin
      w_pc_nxt    = i_epc;
      w_state_nxt = PS_IDLE;
    end else if (w_redirect) begin
      // pc_f already holds the delay slot; it is fetched this cycle or later.
      if (w_advance) begin
        w_pc_nxt    = w_target;
        w_state_nxt = PS_IDLE;
      end else begin
        // Fetch is back-pressured: park the target, newest redirect wins.
        w_pend_pc_nxt = w_target;
        w_state_nxt   = PS_PEND;
      end
    end else if (w_advance) begin
      if (r_state == PS_PEND) begin
        w_pc_nxt    = r_pend_pc;
        w_state_nxt = PS_IDLE;
      end else begin
        w_pc_nxt = r_pc + LP_FOUR;
      end
    end
  end

  // PC, pending target and pending state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc      <= LP_RESET_PC;
      r_pend_pc <= '0;
      r_state   <= PS_IDLE;
    end else begin
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_state   <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table followed by randomized cycles
// checked against a behavioural model of the fetch PC.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, exc_req, eret;
  logic [3:0]  npc_op;
  logic [2:0]  br_cond;
  logic [31:0] rs_val, rt_val, pc_d, epc;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] pc_f;
  logic        br_taken, adel;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_ppc;
  bit          m_pend;

  always #5 clk = ~clk;

  pc_gen dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_imem_ready(imem_ready),
    .i_npc_op(npc_op), .i_br_cond(br_cond), .i_rs_val(rs_val), .i_rt_val(rt_val),
    .i_pc_d(pc_d), .i_imm16(imm16), .i_imm26(imm26), .i_exc_req(exc_req),
    .i_eret(eret), .i_epc(epc), .o_pc_f(pc_f), .o_br_taken(br_taken), .o_adel(adel)
  );

  typedef struct {
    logic rst, stl, rdy;
    logic [3:0] op; logic [2:0] cond;
    logic [31:0] rs, rt, pcd; logic [15:0] i16; logic [25:0] i26;
    logic exc, ert; logic [31:0] epc;
    logic [31:0] exp_pc; logic exp_br, exp_adel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic stl, logic rdy, logic [3:0] op, logic [2:0] cond,
                             logic [31:0] rs, logic [31:0] rt, logic [31:0] pcd, logic [15:0] i16,
                             logic [25:0] i26, logic exc, logic ert, logic [31:0] ep,
                             logic [31:0] exp_pc, logic exp_br, logic exp_adel);
    vec_t r;
    r.rst = rst; r.stl = stl; r.rdy = rdy; r.op = op; r.cond = cond;
    r.rs = rs; r.rt = rt; r.pcd = pcd; r.i16 = i16; r.i26 = i26;
    r.exc = exc; r.ert = ert; r.epc = ep;
    r.exp_pc = exp_pc; r.exp_br = exp_br; r.exp_adel = exp_adel;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_adel(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6ffc);
  endfunction

  // One clock: sample comb outputs mid-cycle, step the model, check registered outputs.
  task automatic cycle(output logic br_s);
    bit          cond, red;
    logic [31:0] tgt;
    @(negedge clk);
    case (br_cond)
      3'd0:    cond = (rs_val == rt_val);
      3'd1:    cond = (rs_val != rt_val);
      3'd2:    cond = ($signed(rs_val) <= 0);
      3'd3:    cond = ($signed(rs_val) > 0);
      3'd4:    cond = ($signed(rs_val) < 0);
      3'd5:    cond = ($signed(rs_val) >= 0);
      default: cond = 0;
    endcase
    if (npc_op == NPC_JR)       tgt = rs_val;
    else if (npc_op == NPC_JAL) tgt = (pc_d & 32'hf000_0000) + {4'h0, imm26, 2'b00};
    else                        tgt = pc_d + 4 + 32'(int'($signed(imm16)) * 4);
    red = !reset && !stall &&
          (npc_op == NPC_JR || npc_op == NPC_JAL || (npc_op == NPC_BRCH && cond));
    br_s = br_taken;
    chk("model_br_taken", {31'd0, br_taken}, {31'd0, red});
    if (!reset)
      assert (!(m_pend && red)) else $error("second redirect while one is pending");
    if (reset) begin
      m_pc = 32'h3000; m_pend = 0;
    end else if (exc_req) begin
      m_pc = 32'h4180; m_pend = 0;
    end else if (eret) begin
      m_pc = epc; m_pend = 0;
    end else if (red && imem_ready) begin
      m_pc = tgt; m_pend = 0;
    end else if (red) begin
      m_ppc = tgt; m_pend = 1;
    end else if (imem_ready && !stall) begin
      if (m_pend) begin m_pc = m_ppc; m_pend = 0; end
      else m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    chk("model_pc_f", pc_f, m_pc);
    chk("model_adel", {31'd0, adel}, {31'd0, m_adel(m_pc)});
  endtask

  initial begin
    logic br_s;
    localparam logic [3:0] A = NPC_ADD4, B = NPC_BRCH, J = NPC_JAL, R = NPC_JR;

    reset = 1; stall = 0; imem_ready = 1; exc_req = 0; eret = 0;
    npc_op = A; br_cond = 0; rs_val = 0; rt_val = 0; pc_d = 0; epc = 0;
    imm16 = 0; imm26 = 0; m_pc = 32'h3000; m_ppc = 0; m_pend = 0;

    //            rst stl rdy op cond rs            rt pcd           i16      i26        exc ert epc      exp_pc        br adel
    vecs.push_back(v(1, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3000,     0, 0));
    vecs.push_back(v(1, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3000,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3004,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3008,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h300c,     0, 0));
    // BEQ taken backwards, then re-enter 0x300c and repeat untaken
    vecs.push_back(v(0, 0, 1, B, 0, 5,            5, 32'h3008,     16'hfffe, 0,        0, 0, 0,       32'h3004,     1, 0));
    vecs.push_back(v(0, 0, 1, R, 0, 32'h300c,     0, 0,            0,       0,         0, 0, 0,       32'h300c,     1, 0));
    vecs.push_back(v(0, 0, 1, B, 0, 5,            6, 32'h3008,     16'hfffe, 0,        0, 0, 0,       32'h3010,     0, 0));
    // sign-based conditions
    vecs.push_back(v(0, 0, 1, B, 4, 32'hffffffff, 0, 32'h300c,     16'h0004, 0,        0, 0, 0,       32'h3020,     1, 0));
    vecs.push_back(v(0, 0, 1, B, 5, 32'hffffffff, 0, 32'h300c,     16'h0004, 0,        0, 0, 0,       32'h3024,     0, 0));
    vecs.push_back(v(0, 0, 1, B, 2, 0,            0, 32'h3020,     16'h0010, 0,        0, 0, 0,       32'h3064,     1, 0));
    vecs.push_back(v(0, 0, 1, B, 3, 0,            0, 32'h3020,     16'h0010, 0,        0, 0, 0,       32'h3068,     0, 0));
    // stall suppresses the redirect; not-ready holds
    vecs.push_back(v(0, 1, 1, R, 0, 32'h3400,     0, 0,            0,       0,         0, 0, 0,       32'h3068,     0, 0));
    vecs.push_back(v(0, 0, 0, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3068,     0, 0));
    // JR 0x3400 seen with pc_f=0x300c (delay slot) while not ready: parked, then applied
    vecs.push_back(v(0, 0, 1, R, 0, 32'h300c,     0, 0,            0,       0,         0, 0, 0,       32'h300c,     1, 0));
    vecs.push_back(v(0, 0, 0, R, 0, 32'h3400,     0, 0,            0,       0,         0, 0, 0,       32'h300c,     1, 0));
    vecs.push_back(v(0, 0, 0, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h300c,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3400,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3404,     0, 0));
    // exception during stall with a pending redirect; pending must be gone afterwards
    vecs.push_back(v(0, 0, 0, R, 0, 32'h3800,     0, 0,            0,       0,         0, 0, 0,       32'h3404,     1, 0));
    vecs.push_back(v(0, 1, 0, A, 0, 0,            0, 0,            0,       0,         1, 0, 0,       32'h4180,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h4184,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         1, 1, 32'h3020, 32'h4180,    0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 1, 32'h3020, 32'h3020,    0, 0));
    // address error boundaries
    vecs.push_back(v(0, 0, 1, R, 0, 32'h3002,     0, 0,            0,       0,         0, 0, 0,       32'h3002,     1, 1));
    vecs.push_back(v(0, 0, 1, R, 0, 32'h7000,     0, 0,            0,       0,         0, 0, 0,       32'h7000,     1, 1));
    vecs.push_back(v(0, 0, 1, R, 0, 32'h6ffc,     0, 0,            0,       0,         0, 0, 0,       32'h6ffc,     1, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h7000,     0, 1));
    vecs.push_back(v(0, 0, 1, R, 0, 32'h2ffc,     0, 0,            0,       0,         0, 0, 0,       32'h2ffc,     1, 1));
    vecs.push_back(v(0, 0, 1, R, 0, 32'h3000,     0, 0,            0,       0,         0, 0, 0,       32'h3000,     1, 0));
    // JAL keeps pc_d[31:28]
    vecs.push_back(v(0, 0, 1, J, 0, 0,            0, 32'ha0003000, 0,       26'h1000,  0, 0, 0,       32'ha0004000, 1, 1));
    vecs.push_back(v(0, 0, 1, J, 0, 0,            0, 32'h00003000, 0,       26'h0c40,  0, 0, 0,       32'h3100,     1, 0));
    // reset drops a pending redirect
    vecs.push_back(v(0, 0, 0, R, 0, 32'h3800,     0, 0,            0,       0,         0, 0, 0,       32'h3100,     1, 0));
    vecs.push_back(v(1, 0, 0, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3000,     0, 0));
    vecs.push_back(v(0, 0, 1, A, 0, 0,            0, 0,            0,       0,         0, 0, 0,       32'h3004,     0, 0));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; stall = vecs[i].stl; imem_ready = vecs[i].rdy;
      npc_op = vecs[i].op; br_cond = vecs[i].cond; rs_val = vecs[i].rs; rt_val = vecs[i].rt;
      pc_d = vecs[i].pcd; imm16 = vecs[i].i16; imm26 = vecs[i].i26;
      exc_req = vecs[i].exc; eret = vecs[i].ert; epc = vecs[i].epc;
      cycle(br_s);
      chk($sformatf("vec%0d_br_taken", i), {31'd0, br_s}, {31'd0, vecs[i].exp_br});
      chk($sformatf("vec%0d_pc_f", i), pc_f, vecs[i].exp_pc);
      chk($sformatf("vec%0d_adel", i), {31'd0, adel}, {31'd0, vecs[i].exp_adel});
    end

    // Randomized traffic; no new redirect is offered while one is parked.
    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom % 60) == 0;
      stall      = ($urandom % 5) == 0;
      imem_ready = ($urandom % 4) != 0;
      exc_req    = ($urandom % 40) == 0;
      eret       = ($urandom % 40) == 0;
      npc_op     = m_pend ? 4'(NPC_ADD4) : 4'($urandom % 5);
      br_cond    = 3'($urandom % 8);
      rt_val     = 32'($urandom_range(0, 6)) - 32'd3;
      case ($urandom % 4)
        0:       rs_val = 0;
        1:       rs_val = rt_val;
        2:       rs_val = $urandom;
        default: rs_val = 32'($urandom_range(0, 6)) - 32'd3;
      endcase
      pc_d  = ($urandom % 2) ? m_pc - 4 : $urandom;
      imm16 = 16'($urandom);
      imm26 = 26'($urandom);
      epc   = 32'h3000 + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom % 2);
      cycle(br_s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
